gate_tester: RTL and testbench
==============================

Name: gate_tester

Overview:
Self-checking stimulus/response engine for 2-input combinational gate blocks such as the team's NOR cell. It drives the gate's a/b inputs through all four input vectors and holds each vector for a settle window. It samples the gate's y output and compares it against a programmable 4-bit truth table. It reports a pass/fail flag, a per-vector fail map and a saturating error count, and is used in the lab bring-up harness and in regression benches.

Parameters:
SETTLE_CYCLES, 2, extra cycles each vector is held before y is sampled (legal 0..255)
PASSES, 1, number of complete sweeps over the 4 vectors per run (legal 1..255)
ERR_W, 8, width of err_count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a run; honoured only in IDLE or DONE
abort  input  1  terminate a run; honoured in RUN
truth_table  input  4  expected y; bit i = y for {a,b}=i (NOR = 4'b0001)
dut_y  input  1  output of gate under test
drv_a  output  1  drives gate input a (registered)
drv_b  output  1  drives gate input b (registered)
busy  output  1  high while in RUN
done  output  1  high in DONE until next start or rst
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  ERR_W  mismatches this run, saturates at all-ones
fail_vec  output  4  sticky; bit i set if vector i ever mismatched this run

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over all inputs.
- Reset values: state=IDLE, drv_a=0, drv_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Internal vector index, pass counter and settle counter are all 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge k:
  - truth_table is latched into an internal register; later changes to the port are ignored until the next start.
  - err_count, fail_vec, done and pass are cleared.
  - idx=0, {drv_a,drv_b}=2'b00, settle counter=SETTLE_CYCLES, state=RUN, busy=1.
- RUN: each vector is held for exactly SETTLE_CYCLES+1 cycles.
  - While settle counter>0: decrement it once per edge; outputs unchanged.
  - On the edge where the counter==0 (sample edge): compare dut_y with latched_tt[idx].
  - On a mismatch: set fail_vec[idx] and increment err_count, saturating with no wrap.
  - On the same sample edge, if more vectors remain: idx=idx+1 (mod 4), {drv_a,drv_b}=new idx, counter reloaded to SETTLE_CYCLES.
  - After idx=3 the pass counter increments. If passes remain, idx wraps to 0, drive=00, and the error count continues to accumulate.
- Terminal sample edge (idx=3, last pass):
  - state=DONE, busy=0, done=1.
  - pass is computed from the count that includes this final sample.
  - drv_a and drv_b return to 0.
- Latency: if start is seen at edge k, done=1 is visible after edge k + 4*(SETTLE_CYCLES+1)*PASSES. For the defaults this is k+12.
- DONE holds all results stable until start or rst.
  - start in DONE begins a new run, with the same behaviour as from IDLE.
  - done drops on that same edge.
- start while in RUN is ignored.
- abort=1 in RUN: state=IDLE, busy=0, drive=00. done stays 0; err_count and fail_vec keep their partial values.
- abort outside RUN has no effect. If abort and start are both high in IDLE/DONE, start wins.
- A combinational DUT is assumed. With SETTLE_CYCLES=0, y is sampled one full cycle after the drive edge.
- rst during RUN: immediate return to reset values on that edge; no done pulse.

Test Plan:
1. NOR model on dut_y, truth_table=4'b0001, defaults, start pulse at edge k -> drive sequence 00,01,10,11, each held 3 cycles; done=1 and pass=1 after edge k+12; err_count=0, fail_vec=0000.
2. dut_y stuck at 0, truth_table=4'b0001 -> done after 12 cycles, pass=0, err_count=1, fail_vec=0001.
3. NOR model, truth_table=4'b1000 (AND expected), PASSES=3 -> err_count=6, fail_vec=1001, done after 36 cycles.
4. ERR_W=2, PASSES=4, dut_y inverted NOR -> 16 mismatches; err_count saturates at 3, fail_vec=1111, pass=0.
5. start pulsed again at cycle 5 of a run -> ignored, done still at k+12. abort at cycle 7 -> IDLE, done=0, drive=00. A new start then gives a clean run with pass=1.
6. rst asserted mid-run and in DONE -> every output returns to its reset value on that edge; change truth_table mid-run -> results reflect the latched value.

Source files
------------

// File: rtl/gate_tester.sv
// Sweeps a 2-input gate through all four input vectors, samples y after a settle window
// and scores it against a latched truth table: pass flag, per-vector fail map, saturating count.
module gate_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       truth_table,
  input  logic             dut_y,
  output logic             drv_a,
  output logic             drv_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       drv_q, drv_d;
  logic [7:0]       settle_q, settle_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [3:0]       tt_q, tt_d;
  logic [3:0]       fail_q, fail_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic             mismatch;
  logic             last_sample;
  logic [ERR_W-1:0] err_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drv_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      tt_q       <= '0;
      fail_q     <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drv_q      <= drv_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      tt_q       <= tt_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
    end
  end

  assign mismatch    = (dut_y != tt_q[idx_q]);
  assign last_sample = (idx_q == 2'd3) && (pass_cnt_q == LAST_PASS);
  assign err_inc     = (err_q == '1) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drv_d      = drv_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    tt_d       = tt_q;
    fail_d     = fail_q;
    err_d      = err_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          tt_d       = truth_table;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          drv_d      = '0;
          settle_d   = SETTLE_INIT;
          pass_cnt_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          // abort wins over a coinciding sample edge; partial results are kept
          state_d    = IDLE;
          idx_d      = '0;
          drv_d      = '0;
          settle_d   = '0;
          pass_cnt_d = '0;
        end else if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          if (mismatch) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_inc;
          end
          if (last_sample) begin
            state_d    = DONE;
            pass_d     = (err_d == '0);
            idx_d      = '0;
            drv_d      = '0;
            pass_cnt_d = '0;
          end else begin
            idx_d    = idx_q + 2'd1;
            drv_d    = idx_q + 2'd1;
            settle_d = SETTLE_INIT;
            if (idx_q == 2'd3) pass_cnt_d = pass_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    drv_a     = drv_q[1];
    drv_b     = drv_q[0];
    pass      = pass_q;
    err_count = err_q;
    fail_vec  = fail_q;
  end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (default timing, and zero-settle/3-pass/2-bit count)
// driven by random gate functions and truth tables, scored against a popcount model.
module tb_gate_tester;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st, ab, y, da, db, bz, dn, ps;
  logic [3:0] tt [2];
  logic [3:0] fv [2];
  logic [3:0] gfun [2];
  logic [7:0] ec0;
  logic [1:0] ec1;
  int         ncmp = 0;
  int         nfail = 0;

  localparam int S [2] = '{2, 0};
  localparam int P [2] = '{1, 3};
  localparam int W [2] = '{8, 2};

  always #5 clk = ~clk;

  // the gate under test is an arbitrary 2-input function: bit {a,b} of gfun
  assign y[0] = gfun[0][{da[0], db[0]}];
  assign y[1] = gfun[1][{da[1], db[1]}];

  gate_tester #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .truth_table(tt[0]), .dut_y(y[0]),
    .drv_a(da[0]), .drv_b(db[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(ec0), .fail_vec(fv[0]));

  gate_tester #(.SETTLE_CYCLES(0), .PASSES(3), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .truth_table(tt[1]), .dut_y(y[1]),
    .drv_a(da[1]), .drv_b(db[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(ec1), .fail_vec(fv[1]));

  function automatic logic [7:0] ecnt(input int i);
    return (i == 0) ? ec0 : {6'b0, ec1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk("rst_busy", 32'(bz[i]), 0);
    chk("rst_done", 32'(dn[i]), 0);
    chk("rst_pass", 32'(ps[i]), 0);
    chk("rst_drv", {30'b0, da[i], db[i]}, 0);
    chk("rst_err", 32'(ecnt(i)), 0);
    chk("rst_fail", 32'(fv[i]), 0);
  endtask

  // Full run: optional stray start at cycle 5, optional abort alongside the start pulse.
  task automatic run(input int i, input logic [3:0] g, input logic [3:0] t,
                     input bit restart_mid, input bit with_abort);
    int lat;
    int mis;
    int sat;
    lat = 4 * (S[i] + 1) * P[i];
    mis = $countones(g ^ t) * P[i];
    sat = (1 << W[i]) - 1;
    if (mis > sat) mis = sat;
    gfun[i] = g;
    tt[i] = t;
    st[i] = 1'b1;
    ab[i] = with_abort;
    step();
    st[i] = 1'b0;
    ab[i] = 1'b0;
    for (int n = 0; n < lat; n++) begin
      chk("run_busy", 32'(bz[i]), 1);
      chk("run_done", 32'(dn[i]), 0);
      chk("run_drv", {30'b0, da[i], db[i]}, 32'((n / (S[i] + 1)) % 4));
      if (n == 0) tt[i] = ~t;
      st[i] = (restart_mid && n == 4);
      step();
    end
    st[i] = 1'b0;
    for (int h = 0; h < 2; h++) begin
      chk("end_done", 32'(dn[i]), 1);
      chk("end_busy", 32'(bz[i]), 0);
      chk("end_drv", {30'b0, da[i], db[i]}, 0);
      chk("end_err", 32'(ecnt(i)), 32'(mis));
      chk("end_fail", 32'(fv[i]), 32'(g ^ t));
      chk("end_pass", 32'(ps[i]), 32'(mis == 0));
      step();
    end
  endtask

  // Abort seen A edges after start on instance 0; samples strictly before it are kept.
  task automatic abort_run(input logic [3:0] g, input logic [3:0] t, input int a);
    logic [3:0] mask;
    int         mis;
    mask = '0;
    mis = 0;
    for (int m = 1; m * (S[0] + 1) < a; m++) begin
      mask[(m - 1) % 4] = 1'b1;
      mis += int'(g[(m - 1) % 4] != t[(m - 1) % 4]);
    end
    gfun[0] = g;
    tt[0] = t;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    for (int n = 0; n < a - 1; n++) step();
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    for (int h = 0; h < 2; h++) begin
      chk("abt_busy", 32'(bz[0]), 0);
      chk("abt_done", 32'(dn[0]), 0);
      chk("abt_drv", {30'b0, da[0], db[0]}, 0);
      chk("abt_err", 32'(ec0), 32'(mis));
      chk("abt_fail", 32'(fv[0]), 32'((g ^ t) & mask));
      ab[0] = 1'b1;
      step();
      ab[0] = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] t;
    int         i;
    rst = 1'b1;
    st = '0;
    ab = '0;
    tt[0] = '0;
    tt[1] = '0;
    gfun[0] = 4'b0001;
    gfun[1] = 4'b0001;
    step();
    step();
    rst = 1'b0;
    step();
    chk_reset(0);
    chk_reset(1);

    run(0, 4'b0001, 4'b0001, 1'b0, 1'b0);
    run(0, 4'b0000, 4'b0001, 1'b0, 1'b0);
    run(1, 4'b0001, 4'b1000, 1'b0, 1'b0);
    run(1, 4'b1110, 4'b0001, 1'b0, 1'b0);
    run(0, 4'b0001, 4'b0001, 1'b1, 1'b1);
    abort_run(4'b0110, 4'b0001, 7);
    run(0, 4'b0001, 4'b0001, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      i = int'($urandom_range(0, 1));
      g = 4'($urandom);
      t = ($urandom_range(0, 3) == 0) ? g : 4'($urandom);
      run(i, g, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    abort_run(4'($urandom), 4'($urandom), int'($urandom_range(2, 11)));

    gfun[0] = 4'b1111;
    tt[0] = 4'b0001;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    for (int n = 0; n < 7; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset(0);
    chk_reset(1);
    step();
    chk_reset(0);

    run(1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
